bcd_to_bin: RTL and testbench

BCD_TO_BIN -- requirements
Module: bcd_to_bin

---
 rtl/bcd_to_bin.sv | 116 +++++++++++
 tb/tb_bcd_to_bin.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// BCD to binary converter using reverse double-dabble.
// One shift-and-correct step per cycle; invalid digits are flagged without converting.
module bcd_to_bin #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int SR_W  = 4*DIGITS + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              err_q, err_d;
  logic              any_bad;

  // Shift right one bit, then pull 3 out of every BCD digit that reached 8 or more.
  function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] t;
    t = s >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (t[BIN_W+4*i +: 4] >= 4'd8)
        t[BIN_W+4*i +: 4] = t[BIN_W+4*i +: 4] - 4'd3;
    end
    return t;
  endfunction

  // Flag any input digit above 9.
  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9)
        any_bad = 1'b1;
    end
  end

  // Next-state and datapath updates for IDLE / CONV / DONE.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (any_bad) begin
            err_d   = 1'b1;
            bin_d   = '0;
            state_d = DONE;
          end else begin
            sr_d    = {bcd_in, {BIN_W{1'b0}}};
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = CONV;
          end
        end
      end
      CONV: begin
        if (cnt_q == LAST) begin
          bin_d   = sr_q[BIN_W-1:0];
          state_d = DONE;
        end else begin
          sr_d  = dabble(sr_q);
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign bin_out = bin_q;
  assign err     = err_q;
  assign busy    = (state_q == CONV);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_bcd_to_bin.sv
// Randomized and directed bench for bcd_to_bin.
// A timeline model predicts busy/done/err/bin_out on every cycle.
module tb_bcd_to_bin;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [11:0]      bcd_in = '0;
  logic [BIN_W-1:0] bin_out;
  logic             busy;
  logic             done;
  logic             err;

  int total = 0;
  int bad = 0;

  bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bcd_in(bcd_in),
    .bin_out(bin_out),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal value of a packed BCD word; e set when a digit is out of range.
  function automatic int ref_val(input logic [11:0] b, output bit e);
    int v;
    int w;
    int d;
    v = 0;
    w = 1;
    e = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) e = 1'b1;
      v += d * w;
      w *= 10;
    end
    return e ? 0 : v;
  endfunction

  // Timeline model: edge indices of the accepted request and its done cycle.
  int cyc = 0;
  int acc_n = -100;
  bit acc_valid = 1'b0;
  int d_edge = -100;
  int free_from = 0;
  int res_bin = 0;
  bit res_err = 1'b0;
  int exp_bin = 0;
  bit exp_err = 1'b0;
  bit exp_busy = 1'b0;
  bit exp_done = 1'b0;
  bit seen_reset = 1'b0;

  always @(posedge clk) begin
    bit e;
    int v;
    cyc++;
    if (reset) begin
      seen_reset = 1'b1;
      acc_n = -100;
      acc_valid = 1'b0;
      d_edge = -100;
      free_from = cyc + 1;
      exp_bin = 0;
      exp_err = 1'b0;
    end else begin
      if (start && cyc >= free_from) begin
        v = ref_val(bcd_in, e);
        acc_n = cyc;
        acc_valid = !e;
        res_bin = v;
        res_err = e;
        d_edge = e ? cyc : cyc + BIN_W + 1;
        free_from = d_edge + 2;
        if (!e) exp_err = 1'b0;
      end
      if (cyc == d_edge) begin
        exp_bin = res_err ? 0 : res_bin;
        exp_err = res_err;
      end
    end
    exp_busy = acc_valid && cyc >= acc_n && cyc <= acc_n + BIN_W;
    exp_done = (cyc == d_edge);
  end

  // Compare every cycle once reset has been seen.
  always @(negedge clk) begin
    if (seen_reset) begin
      check("busy", int'(busy), int'(exp_busy));
      check("done", int'(done), int'(exp_done));
      check("err", int'(err), int'(exp_err));
      if (!exp_busy)
        check("bin_out", int'(bin_out), exp_bin);
    end
  end

  task automatic do_conv(input logic [11:0] b, input int xb, input bit xe,
                         input string name);
    bit got;
    got = 1'b0;
    @(negedge clk);
    start = 1'b1;
    bcd_in = b;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (done) begin
        got = 1'b1;
        check({name, "_bin"}, int'(bin_out), xb);
        check({name, "_err"}, int'(err), int'(xe));
      end
    end
    if (!got) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    bit e;
    int busy_cnt;
    check("ref_255", ref_val(12'h255, e), 255);
    check("ref_999", ref_val(12'h999, e), 999);
    check("ref_9a3_err", int'(e), 0);
    void'(ref_val(12'h9A3, e));
    check("ref_9a3_err", int'(e), 1);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_bin", int'(bin_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);

    // Count busy cycles of one conversion.
    @(negedge clk);
    start = 1'b1;
    bcd_in = 12'h255;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    check("busy_len", busy_cnt, BIN_W + 1);
    check("c255_bin", int'(bin_out), 255);
    check("c255_err", int'(err), 0);

    do_conv(12'h999, 999, 1'b0, "c999");
    do_conv(12'h000, 0, 1'b0, "c000");
    do_conv(12'h9A3, 0, 1'b1, "c9a3");
    do_conv(12'h001, 1, 1'b0, "c001");

    // Second start mid-conversion must be ignored.
    @(negedge clk);
    start = 1'b1;
    bcd_in = 12'h123;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    bcd_in = 12'h456;
    @(negedge clk);
    start = 1'b0;
    wait_done("c123");
    check("c123_bin", int'(bin_out), 123);

    // Reset mid-conversion aborts it.
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    bcd_in = 12'h500;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_bin", int'(bin_out), 0);
    repeat (15) @(negedge clk);
    do_conv(12'h042, 42, 1'b0, "c042");

    // Random traffic, including starts while busy and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < DIGITS; i++) begin
        if ($urandom_range(0, 7) == 0)
          bcd_in[4*i +: 4] = 4'($urandom_range(0, 15));
        else
          bcd_in[4*i +: 4] = 4'($urandom_range(0, 9));
      end
    end
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
